// File: rtl/mt_ckpt.sv
// Rename map table: N-wide rename with intra-group forwarding, CDB-woken
// ready bits, branch checkpoints and an architectural map for flush.
module mt_ckpt #(
    parameter int AR_W      = 5,
    parameter int PR_W      = 7,
    parameter int DISP_W    = 2,
    parameter int CDB_WIDTH = 4,
    parameter int NUM_CKPT  = 4,
    localparam int CK_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int LN_W     = (DISP_W > 1) ? $clog2(DISP_W) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DISP_W-1:0]         disp_valid,
    input  logic [DISP_W-1:0]         disp_dst_vld,
    input  logic [DISP_W*AR_W-1:0]    disp_ar_dst,
    input  logic [DISP_W*PR_W-1:0]    disp_pr_new,
    input  logic [DISP_W*AR_W-1:0]    disp_ar_src1,
    input  logic [DISP_W*AR_W-1:0]    disp_ar_src2,
    output logic [DISP_W*PR_W-1:0]    rs_pr_src1,
    output logic [DISP_W*PR_W-1:0]    rs_pr_src2,
    output logic [DISP_W-1:0]         rs_rdy_src1,
    output logic [DISP_W-1:0]         rs_rdy_src2,
    output logic [DISP_W*PR_W-1:0]    rob_told,
    input  logic [CDB_WIDTH-1:0]      cdb_valid,
    input  logic [CDB_WIDTH*PR_W-1:0] cdb_pr_tag,
    input  logic                      ckpt_take,
    input  logic [LN_W-1:0]           ckpt_lane,
    input  logic [CK_W-1:0]           ckpt_id,
    input  logic                      recover,
    input  logic [CK_W-1:0]           recover_id,
    input  logic [DISP_W-1:0]         ret_valid,
    input  logic [DISP_W*AR_W-1:0]    ret_ar,
    input  logic [DISP_W*PR_W-1:0]    ret_pr,
    input  logic                      flush
);

    localparam int NUM_AR = 2**AR_W;
    localparam int NUM_PR = 2**PR_W;

    logic [PR_W-1:0]   r_spec_map [NUM_AR];
    logic [PR_W-1:0]   r_arch_map [NUM_AR];
    logic [PR_W-1:0]   r_ckpt     [NUM_CKPT][NUM_AR];
    logic [NUM_PR-1:0] r_ready;

    logic [DISP_W-1:0] w_wr;
    logic              w_disp_en;
    logic [PR_W-1:0]   w_stage    [DISP_W][NUM_AR];
    logic [PR_W-1:0]   w_arch_next[NUM_AR];
    logic [NUM_PR-1:0] w_ready_next;

    assign w_wr      = disp_valid & disp_dst_vld;
    assign w_disp_en = !flush && !recover;

    // Source/told lookup: youngest older lane in the group overrides the map
    always_comb begin : rename
        logic [AR_W-1:0] v_s1, v_s2, v_dst, v_odst;
        logic [PR_W-1:0] v_p1, v_p2, v_pt, v_onew;
        logic            v_r1, v_r2;
        v_s1 = '0; v_s2 = '0; v_dst = '0; v_odst = '0;
        v_p1 = '0; v_p2 = '0; v_pt = '0; v_onew = '0;
        v_r1 = 1'b0; v_r2 = 1'b0;
        rs_pr_src1  = '0;
        rs_pr_src2  = '0;
        rs_rdy_src1 = '0;
        rs_rdy_src2 = '0;
        rob_told    = '0;
        for (int unsigned j = 0; j < DISP_W; j++) begin
            v_s1  = disp_ar_src1[j*AR_W +: AR_W];
            v_s2  = disp_ar_src2[j*AR_W +: AR_W];
            v_dst = disp_ar_dst[j*AR_W +: AR_W];
            v_p1  = r_spec_map[v_s1];
            v_p2  = r_spec_map[v_s2];
            v_pt  = r_spec_map[v_dst];
            v_r1  = r_ready[v_p1];
            v_r2  = r_ready[v_p2];
            for (int unsigned i = 0; i < j; i++) begin
                v_odst = disp_ar_dst[i*AR_W +: AR_W];
                v_onew = disp_pr_new[i*PR_W +: PR_W];
                if (w_wr[i] && v_odst == v_s1) begin
                    v_p1 = v_onew;
                    v_r1 = 1'b0;
                end
                if (w_wr[i] && v_odst == v_s2) begin
                    v_p2 = v_onew;
                    v_r2 = 1'b0;
                end
                if (w_wr[i] && v_odst == v_dst) begin
                    v_pt = v_onew;
                end
            end
            rs_pr_src1[j*PR_W +: PR_W] = v_p1;
            rs_pr_src2[j*PR_W +: PR_W] = v_p2;
            rs_rdy_src1[j]             = v_r1;
            rs_rdy_src2[j]             = v_r2;
            rob_told[j*PR_W +: PR_W]   = v_pt;
        end
    end

    // Stage k is the speculative map with lanes 0..k applied (higher lane wins)
    always_comb begin
        for (int unsigned k = 0; k < DISP_W; k++) begin
            for (int unsigned a = 0; a < NUM_AR; a++) begin
                w_stage[k][a] = r_spec_map[a];
                for (int unsigned i = 0; i <= k; i++) begin
                    if (w_wr[i] && disp_ar_dst[i*AR_W +: AR_W] == AR_W'(a)) begin
                        w_stage[k][a] = disp_pr_new[i*PR_W +: PR_W];
                    end
                end
            end
        end
    end

    // Architectural map after this cycle's retires (higher lane wins)
    always_comb begin
        for (int unsigned a = 0; a < NUM_AR; a++) begin
            w_arch_next[a] = r_arch_map[a];
            for (int unsigned i = 0; i < DISP_W; i++) begin
                if (ret_valid[i] && ret_ar[i*AR_W +: AR_W] == AR_W'(a)) begin
                    w_arch_next[a] = ret_pr[i*PR_W +: PR_W];
                end
            end
        end
    end

    // Ready bits: CDB sets, then new allocations clear so a same-cycle clear wins
    always_comb begin
        w_ready_next = r_ready;
        for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
            if (cdb_valid[k]) begin
                w_ready_next[cdb_pr_tag[k*PR_W +: PR_W]] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < DISP_W; i++) begin
            if (w_disp_en && w_wr[i]) begin
                w_ready_next[disp_pr_new[i*PR_W +: PR_W]] = 1'b0;
            end
        end
    end

    // State update with priority flush > recover > dispatch/checkpoint
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned a = 0; a < NUM_AR; a++) begin
                r_spec_map[a] <= PR_W'(a);
                r_arch_map[a] <= PR_W'(a);
                for (int unsigned c = 0; c < NUM_CKPT; c++) begin
                    r_ckpt[c][a] <= PR_W'(a);
                end
            end
            r_ready <= '1;
        end else begin
            for (int unsigned a = 0; a < NUM_AR; a++) begin
                r_arch_map[a] <= w_arch_next[a];
                if (flush) begin
                    r_spec_map[a] <= w_arch_next[a];
                end else if (recover) begin
                    r_spec_map[a] <= r_ckpt[recover_id][a];
                end else begin
                    r_spec_map[a] <= w_stage[DISP_W-1][a];
                    if (ckpt_take) begin
                        r_ckpt[ckpt_id][a] <= w_stage[ckpt_lane][a];
                    end
                end
            end
            r_ready <= w_ready_next;
        end
    end

endmodule

// File: tb/tb_mt_ckpt.sv
// Bench for mt_ckpt: directed vector table, then random traffic against a reference model.
module tb_mt_ckpt;

    localparam int AR_W = 5;
    localparam int PR_W = 7;
    localparam int DW   = 2;
    localparam int CW   = 4;
    localparam int NC   = 4;
    localparam int NAR  = 2**AR_W;
    localparam int NPR  = 2**PR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic [DW-1:0]     disp_valid, disp_dst_vld;
    logic [DW*AR_W-1:0] disp_ar_dst, disp_ar_src1, disp_ar_src2;
    logic [DW*PR_W-1:0] disp_pr_new;
    logic [DW*PR_W-1:0] rs_pr_src1, rs_pr_src2, rob_told;
    logic [DW-1:0]     rs_rdy_src1, rs_rdy_src2;
    logic [CW-1:0]     cdb_valid;
    logic [CW*PR_W-1:0] cdb_pr_tag;
    logic              ckpt_take;
    logic [0:0]        ckpt_lane;
    logic [1:0]        ckpt_id;
    logic              recover;
    logic [1:0]        recover_id;
    logic [DW-1:0]     ret_valid;
    logic [DW*AR_W-1:0] ret_ar;
    logic [DW*PR_W-1:0] ret_pr;
    logic              flush;

    always #5 clock = ~clock;

    mt_ckpt #(.AR_W(AR_W), .PR_W(PR_W), .DISP_W(DW), .CDB_WIDTH(CW), .NUM_CKPT(NC)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_dst_vld(disp_dst_vld),
        .disp_ar_dst(disp_ar_dst), .disp_pr_new(disp_pr_new),
        .disp_ar_src1(disp_ar_src1), .disp_ar_src2(disp_ar_src2),
        .rs_pr_src1(rs_pr_src1), .rs_pr_src2(rs_pr_src2),
        .rs_rdy_src1(rs_rdy_src1), .rs_rdy_src2(rs_rdy_src2),
        .rob_told(rob_told),
        .cdb_valid(cdb_valid), .cdb_pr_tag(cdb_pr_tag),
        .ckpt_take(ckpt_take), .ckpt_lane(ckpt_lane), .ckpt_id(ckpt_id),
        .recover(recover), .recover_id(recover_id),
        .ret_valid(ret_valid), .ret_ar(ret_ar), .ret_pr(ret_pr),
        .flush(flush)
    );

    // Per-lane stimulus kept as plain integers
    int l_dst[DW], l_new[DW], l_s1[DW], l_s2[DW], l_rar[DW], l_rpr[DW], l_cdb[CW];
    logic [DW-1:0] l_dv, l_dd, l_retv;
    logic [CW-1:0] l_cdbv;
    bit l_ck, l_rec, l_fl;
    int l_cklane, l_ckid, l_recid;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_spec[NAR];
    int m_arch[NAR];
    int m_ck[NC][NAR];
    bit m_rdy[NPR];

    task automatic drive();
        for (int i = 0; i < DW; i++) begin
            disp_ar_dst[i*AR_W +: AR_W]  = AR_W'(l_dst[i]);
            disp_ar_src1[i*AR_W +: AR_W] = AR_W'(l_s1[i]);
            disp_ar_src2[i*AR_W +: AR_W] = AR_W'(l_s2[i]);
            disp_pr_new[i*PR_W +: PR_W]  = PR_W'(l_new[i]);
            ret_ar[i*AR_W +: AR_W]       = AR_W'(l_rar[i]);
            ret_pr[i*PR_W +: PR_W]       = PR_W'(l_rpr[i]);
        end
        for (int k = 0; k < CW; k++) cdb_pr_tag[k*PR_W +: PR_W] = PR_W'(l_cdb[k]);
        disp_valid   = l_dv;
        disp_dst_vld = l_dd;
        ret_valid    = l_retv;
        cdb_valid    = l_cdbv;
        ckpt_take    = l_ck;
        ckpt_lane    = 1'(l_cklane);
        ckpt_id      = 2'(l_ckid);
        recover      = l_rec;
        recover_id   = 2'(l_recid);
        flush        = l_fl;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < DW; i++) begin
            l_dst[i] = 0; l_new[i] = 0; l_s1[i] = 0; l_s2[i] = 0; l_rar[i] = 0; l_rpr[i] = 0;
        end
        for (int k = 0; k < CW; k++) l_cdb[k] = 0;
        l_dv = '0; l_dd = '0; l_retv = '0; l_cdbv = '0;
        l_ck = 0; l_rec = 0; l_fl = 0; l_cklane = 0; l_ckid = 0; l_recid = 0;
    endtask

    task automatic chk(input string nm, input int lane, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s lane%0d at %0t: got %0d expected %0d", nm, lane, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < NAR; a++) begin
            m_spec[a] = a;
            m_arch[a] = a;
            for (int c = 0; c < NC; c++) m_ck[c][a] = a;
        end
        for (int p = 0; p < NPR; p++) m_rdy[p] = 1'b1;
    endtask

    // Rename as the RS sees it: scan older lanes from youngest down, else the map
    task automatic m_lookup(input int j, input int ar, output int pr, output int rdy);
        pr = m_spec[ar];
        rdy = m_rdy[pr];
        for (int i = j - 1; i >= 0; i--) begin
            if (l_dv[i] && l_dd[i] && l_dst[i] == ar) begin
                pr = l_new[i];
                rdy = 0;
                break;
            end
        end
    endtask

    // Model of one clock edge, in program order
    task automatic model_step();
        for (int i = 0; i < DW; i++) if (l_retv[i]) m_arch[l_rar[i]] = l_rpr[i];
        for (int k = 0; k < CW; k++) if (l_cdbv[k]) m_rdy[l_cdb[k]] = 1'b1;
        if (!l_fl && !l_rec)
            for (int i = 0; i < DW; i++) if (l_dv[i] && l_dd[i]) m_rdy[l_new[i]] = 1'b0;
        if (l_fl) begin
            for (int a = 0; a < NAR; a++) m_spec[a] = m_arch[a];
        end else if (l_rec) begin
            for (int a = 0; a < NAR; a++) m_spec[a] = m_ck[l_recid][a];
        end else begin
            for (int i = 0; i < DW; i++) begin
                if (l_dv[i] && l_dd[i]) m_spec[l_dst[i]] = l_new[i];
                if (l_ck && i == l_cklane)
                    for (int a = 0; a < NAR; a++) m_ck[l_ckid][a] = m_spec[a];
            end
        end
    endtask

    task automatic check_model();
        int p, r;
        for (int j = 0; j < DW; j++) begin
            m_lookup(j, l_s1[j], p, r);
            chk("src1_tag", j, int'(rs_pr_src1[j*PR_W +: PR_W]), p);
            chk("src1_rdy", j, int'(rs_rdy_src1[j]), r);
            m_lookup(j, l_s2[j], p, r);
            chk("src2_tag", j, int'(rs_pr_src2[j*PR_W +: PR_W]), p);
            chk("src2_rdy", j, int'(rs_rdy_src2[j]), r);
            m_lookup(j, l_dst[j], p, r);
            chk("told", j, int'(rob_told[j*PR_W +: PR_W]), p);
        end
    endtask

    typedef struct {
        logic [1:0] dv; logic [1:0] dd;
        int dst0; int dst1; int new0; int new1;
        int s10; int s11; int s20; int s21;
        bit cdb40; bit ck; bit rec; bit fl; bit retv; int rar; int rpr;
        int ep10; int ep11; logic [1:0] er1;
        int ep20; int ep21; logic [1:0] er2;
        int et0; int et1;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl[NV];

    initial begin
        // dv dd dst0 dst1 new0 new1 s1_0 s1_1 s2_0 s2_1 cdb40 ck rec fl retv rar rpr | p1_0 p1_1 rdy1 p2_0 p2_1 rdy2 told0 told1
        tbl[0]  = '{2'b00, 2'b00, 5, 5,  0,  0, 3, 3, 31, 31, 0, 0, 0, 0, 0, 0,  0,  3,  3, 2'b11, 31, 31, 2'b11,  5,  5};
        tbl[1]  = '{2'b11, 2'b11, 4, 4, 40, 41, 4, 4,  0,  0, 0, 0, 0, 0, 0, 0,  0,  4, 40, 2'b01,  0,  0, 2'b11,  4, 40};
        tbl[2]  = '{2'b00, 2'b00, 4, 4,  0,  0, 4, 4,  0,  0, 1, 0, 0, 0, 0, 0,  0, 41, 41, 2'b00,  0,  0, 2'b11, 41, 41};
        tbl[3]  = '{2'b01, 2'b01, 4, 4, 40,  0, 4, 4,  0,  0, 1, 0, 0, 0, 0, 0,  0, 41, 40, 2'b00,  0,  0, 2'b11, 41, 40};
        tbl[4]  = '{2'b00, 2'b00, 4, 4,  0,  0, 4, 4,  0,  0, 1, 0, 0, 0, 0, 0,  0, 40, 40, 2'b00,  0,  0, 2'b11, 40, 40};
        tbl[5]  = '{2'b00, 2'b00, 4, 4,  0,  0, 4, 4,  0,  0, 0, 0, 0, 0, 0, 0,  0, 40, 40, 2'b11,  0,  0, 2'b11, 40, 40};
        tbl[6]  = '{2'b11, 2'b11, 1, 1, 50, 51, 1, 1,  0,  0, 0, 1, 0, 0, 0, 0,  0,  1, 50, 2'b01,  0,  0, 2'b11,  1, 50};
        tbl[7]  = '{2'b01, 2'b01, 1, 1, 52,  0, 1, 1,  0,  0, 0, 0, 0, 0, 0, 0,  0, 51, 52, 2'b00,  0,  0, 2'b11, 51, 52};
        tbl[8]  = '{2'b01, 2'b01, 1, 1, 53,  0, 1, 1,  0,  0, 0, 0, 1, 0, 0, 0,  0, 52, 53, 2'b00,  0,  0, 2'b11, 52, 53};
        tbl[9]  = '{2'b00, 2'b00, 1, 4,  0,  0, 1, 1,  4,  4, 0, 0, 0, 0, 0, 0,  0, 50, 50, 2'b00, 40, 40, 2'b11, 50, 40};
        tbl[10] = '{2'b01, 2'b01, 7, 7, 61,  0, 7, 7,  0,  0, 0, 0, 0, 0, 1, 7, 60,  7, 61, 2'b01,  0,  0, 2'b11,  7, 61};
        tbl[11] = '{2'b00, 2'b00, 7, 7,  0,  0, 7, 7,  0,  0, 0, 0, 1, 1, 0, 0,  0, 61, 61, 2'b00,  0,  0, 2'b11, 61, 61};
        tbl[12] = '{2'b00, 2'b00, 1, 4,  0,  0, 7, 4,  1,  7, 0, 0, 0, 0, 0, 0,  0, 60,  4, 2'b11,  1, 60, 2'b11,  1,  4};
        tbl[13] = '{2'b00, 2'b00, 2, 2,  0,  0, 2, 2,  7,  7, 0, 0, 0, 1, 1, 2, 70,  2,  2, 2'b11, 60, 60, 2'b11,  2,  2};
        tbl[14] = '{2'b00, 2'b00, 2, 2,  0,  0, 2, 2,  7,  7, 0, 0, 0, 0, 0, 0,  0, 70, 70, 2'b11, 60, 60, 2'b11, 70, 70};

        clear_stim();
        drive();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Directed scenarios against hand-computed expectations
        for (int v = 0; v < NV; v++) begin
            @(negedge clock);
            clear_stim();
            l_dv = tbl[v].dv; l_dd = tbl[v].dd;
            l_dst[0] = tbl[v].dst0; l_dst[1] = tbl[v].dst1;
            l_new[0] = tbl[v].new0; l_new[1] = tbl[v].new1;
            l_s1[0] = tbl[v].s10; l_s1[1] = tbl[v].s11;
            l_s2[0] = tbl[v].s20; l_s2[1] = tbl[v].s21;
            l_cdbv = tbl[v].cdb40 ? 4'b0100 : 4'b0000;
            l_cdb[2] = 40;
            l_ck = tbl[v].ck; l_cklane = 0; l_ckid = 2;
            l_rec = tbl[v].rec; l_recid = 2;
            l_fl = tbl[v].fl;
            l_retv = {1'b0, tbl[v].retv}; l_rar[0] = tbl[v].rar; l_rpr[0] = tbl[v].rpr;
            drive();
            #1;
            chk("tbl_src1_tag", 0, int'(rs_pr_src1[0 +: PR_W]), tbl[v].ep10);
            chk("tbl_src1_tag", 1, int'(rs_pr_src1[PR_W +: PR_W]), tbl[v].ep11);
            chk("tbl_src1_rdy", v, int'(rs_rdy_src1), int'(tbl[v].er1));
            chk("tbl_src2_tag", 0, int'(rs_pr_src2[0 +: PR_W]), tbl[v].ep20);
            chk("tbl_src2_tag", 1, int'(rs_pr_src2[PR_W +: PR_W]), tbl[v].ep21);
            chk("tbl_src2_rdy", v, int'(rs_rdy_src2), int'(tbl[v].er2));
            chk("tbl_told", 0, int'(rob_told[0 +: PR_W]), tbl[v].et0);
            chk("tbl_told", 1, int'(rob_told[PR_W +: PR_W]), tbl[v].et1);
        end

        // Random traffic against the reference model
        @(negedge clock);
        clear_stim();
        drive();
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < DW; i++) begin
                bit wide;
                wide = ($urandom_range(0, 3) == 0);
                l_dst[i] = wide ? $urandom_range(0, NAR-1) : $urandom_range(0, 7);
                l_s1[i]  = wide ? $urandom_range(0, NAR-1) : $urandom_range(0, 7);
                l_s2[i]  = $urandom_range(0, 7);
                l_new[i] = $urandom_range(0, NPR-1);
                l_rar[i] = $urandom_range(0, 7);
                l_rpr[i] = $urandom_range(0, NPR-1);
            end
            for (int k = 0; k < CW; k++) l_cdb[k] = $urandom_range(0, NPR-1);
            l_dv = 2'($urandom);
            l_dd = 2'($urandom);
            l_retv = 2'($urandom);
            l_cdbv = 4'($urandom);
            l_ck = ($urandom_range(0, 3) == 0);
            l_cklane = $urandom_range(0, 1);
            l_ckid = $urandom_range(0, NC-1);
            l_rec = ($urandom_range(0, 11) == 0);
            l_recid = $urandom_range(0, NC-1);
            l_fl = ($urandom_range(0, 24) == 0);
            drive();
            #1;
            check_model();
            if (cyc == 700) begin
                // Asynchronous reset between edges: outputs must snap to reset values
                l_dv = '0;
                drive();
                #1 reset = 1'b0;
                #1;
                for (int j = 0; j < DW; j++) begin
                    chk("rst_src1_tag", j, int'(rs_pr_src1[j*PR_W +: PR_W]), l_s1[j]);
                    chk("rst_src1_rdy", j, int'(rs_rdy_src1[j]), 1);
                    chk("rst_src2_tag", j, int'(rs_pr_src2[j*PR_W +: PR_W]), l_s2[j]);
                    chk("rst_src2_rdy", j, int'(rs_rdy_src2[j]), 1);
                    chk("rst_told", j, int'(rob_told[j*PR_W +: PR_W]), l_dst[j]);
                end
                #1 reset = 1'b1;
                model_reset();
            end
            model_step();
        end

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
